// File: rtl/mux_nx1_reg_pkg.sv
// Shared definitions for the registered N-to-1 channel multiplexer.
package mux_nx1_reg_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

endpackage

// File: rtl/mux_nx1_reg_rr_arbiter.sv
// Combinational rotate-priority search: first requester after last_grant wins.
module rr_arbiter
    import mux_nx1_reg_pkg::*;
#(
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    input  logic             en,
    output logic [SEL_W-1:0] grant,
    output logic             grant_vld
);

    int unsigned      idx;
    logic [SEL_W-1:0] idx_s;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_s = '0;
        // Offsets run 1..N_CH so a lone requester at last_grant still wins.
        for (int unsigned off = 1; off <= N_CH; off++) begin
            idx   = (32'(last_grant) + off) % N_CH;
            idx_s = SEL_W'(idx);
            if (!found && req[idx_s]) begin
                found = 1'b1;
                grant = idx_s;
            end
        end
        grant_vld = en && (|req);
    end

endmodule

// File: rtl/mux_nx1_reg.sv
// Registered N-to-1 channel mux with valid/ready handshake; direct select
// or round-robin arbitration chosen at run time.
module mux_nx1_reg
    import mux_nx1_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    mode_e            mode_q;
    logic             load;
    logic             sel_ok;
    logic             grant_vld;
    logic             rr_vld;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] rr_grant;
    logic [SEL_W-1:0] last_grant;
    logic [WIDTH-1:0] ch_data [N_CH];

    assign mode_q = mode_e'(mode);
    assign load   = !out_valid || out_ready;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req        (in_valid),
        .last_grant (last_grant),
        .en         (mode_q == MODE_RR),
        .grant      (rr_grant),
        .grant_vld  (rr_vld)
    );

    always_comb begin
        sel_ok    = 32'(sel) < N_CH;
        grant     = sel;
        grant_vld = sel_ok && in_valid[sel];
        if (mode_q == MODE_RR) begin
            grant     = rr_grant;
            grant_vld = rr_vld;
        end
    end

    assign in_ready = (rst_n && load && grant_vld) ? (N_CH'(1) << grant) : '0;

    // A granted channel is always valid, so load && grant_vld is the transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            last_grant <= SEL_W'(N_CH - 1);
        end else if (load) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= ch_data[grant];
                out_ch   <= grant;
                if (mode_q == MODE_RR) begin
                    last_grant <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Randomized bench for mux_nx1_reg against a behavioural model, with directed
// literal checks of reset, direct select, fairness, wrap and back-pressure.
module tb_mux_nx1_reg;

    localparam int W = 8;
    localparam int N = 4;
    localparam int SW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_ch;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    d [N];

    int n_vec = 0;
    int n_err = 0;

    // Model state: output register contents and round-robin pointer.
    int m_valid, m_data, m_ch, m_ptr;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) in_data[i*W +: W] = d[i];
    end

    mux_nx1_reg #(.WIDTH(W), .N_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Channel that wins under the current inputs, or -1 when none is served.
    function automatic int exp_grant();
        int c;
        if (mode == 1'b0) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic int exp_ready();
        int g;
        g = exp_grant();
        if (rst_n && (m_valid == 0 || out_ready) && g >= 0) return 1 << g;
        return 0;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_n) begin
            m_valid = 0; m_data = 0; m_ch = 0; m_ptr = N - 1;
        end else if (m_valid == 0 || out_ready) begin
            g = exp_grant();
            if (g >= 0) begin
                m_valid = 1; m_data = int'(d[g]); m_ch = g;
                if (mode) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("out_valid", int'(out_valid), m_valid);
        chk("out_data", int'(out_data), m_data);
        chk("out_ch", int'(out_ch), m_ch);
        chk("in_ready", int'(in_ready), exp_ready());
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_data(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c, input logic [W-1:0] e);
        d[0] = a; d[1] = b; d[2] = c; d[3] = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] seq_d [N];
        seq_d[0] = 8'h11; seq_d[1] = 8'h22; seq_d[2] = 8'h33; seq_d[3] = 8'h44;

        rst_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_valid = 4'b1111;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        tick(); tick();
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_ch", int'(out_ch), 0);
        chk("rst_ready", int'(in_ready), 0);

        rst_n = 1'b1;
        #1 chk("first_ready", int'(in_ready), 4'b0001);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("fair_ch", int'(out_ch), i % 4);
            chk("fair_data", int'(out_data), int'(seq_d[i % 4]));
        end

        mode = 1'b0; sel = 2'd2; d[2] = 8'hA5; in_valid = 4'b0100;
        #1 chk("sel_ready", int'(in_ready), 4'b0100);
        tick();
        chk("sel_data", int'(out_data), 8'hA5);
        chk("sel_ch", int'(out_ch), 2);
        chk("sel_valid", int'(out_valid), 1);
        sel = 2'd1;
        #1 chk("sel_idle_ready", int'(in_ready), 0);
        tick();
        chk("sel_idle_valid", int'(out_valid), 0);
        chk("sel_idle_hold", int'(out_data), 8'hA5);

        mode = 1'b1; in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wrap_ch", int'(out_ch), (i % 2 == 0) ? 0 : 3);
        end
        in_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_ch", int'(out_ch), 3);
            chk("single_valid", int'(out_valid), 1);
        end

        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        in_valid = 4'b0010;
        tick();
        chk("bp_setup_ch", int'(out_ch), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'($urandom);
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            #1 chk("bp_ready", int'(in_ready), 0);
            tick();
            chk("bp_ch", int'(out_ch), 1);
            chk("bp_data", int'(out_data), 8'h22);
            chk("bp_valid", int'(out_valid), 1);
        end
        in_valid = 4'b1111; out_ready = 1'b1;
        #1 chk("bp_release_ready", int'(in_ready), 4'b0100);
        tick();
        chk("bp_release_ch", int'(out_ch), 2);

        out_ready = 1'b0; rst_n = 1'b0;
        tick();
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_ch", int'(out_ch), 0);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 chk("midrst_ptr_ready", int'(in_ready), 4'b0001);

        for (int i = 0; i < 3000; i++) begin
            tick();
            rst_n     = ($urandom_range(0, 63) != 0);
            mode      = 1'($urandom);
            sel       = SW'($urandom);
            in_valid  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 1) << $urandom_range(0, 3))
                                                    : 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
